// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame states, prefix codes and FIFO entry layout
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int ENTRY_W  = 10;
  localparam int CODE_LSB = 0;
  localparam int BRK_BIT  = 8;
  localparam int EXT_BIT  = 9;
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: oversampled PS/2 byte receiver with parity, stop and timeout checks
module ps2_frame_rx import ps2_pkg::*; #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk_100Mhz,
  input  logic       rst,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       parity_err,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  logic filt, filt_d, fall, ps2c_s, ps2d_s, par;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  ps2_state_t state;
  assign ps2c_s  = clk_sync[SYNC_STAGES-1];
  assign ps2d_s  = dat_sync[SYNC_STAGES-1];
  assign fall    = filt_d & ~filt;
  assign rx_byte = shreg;
  // synchronise both lines and only move the filtered clock after a stable run
  always_ff @(posedge clk_100Mhz or posedge rst)
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2Clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2Data};
      filt_d   <= filt;
      filt_cnt <= (ps2c_s == filt || filt_cnt == FW'(FILTER_LEN - 1)) ? '0 : filt_cnt + FW'(1);
      if (ps2c_s != filt && filt_cnt == FW'(FILTER_LEN - 1)) filt <= ps2c_s;
    end
  // frame FSM stepping on filtered falling edges, aborted by the inter-bit timeout
  always_ff @(posedge clk_100Mhz or posedge rst)
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      to_cnt     <= '0;
      byte_ok    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_ok    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      to_cnt     <= (fall || state == IDLE) ? '0 : to_cnt + TW'(1);
      if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (fall)
        case (state)
          IDLE: if (!ps2d_s) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {ps2d_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= ps2d_s;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if (!(^{shreg, par})) parity_err <= 1'b1;
            else if (!ps2d_s) frame_err <= 1'b1;
            else byte_ok <= 1'b1;
          end
        endcase
    end
endmodule

// File: rtl/ps2_keycode_fifo.sv
// ps2_keycode_fifo: PS/2 receiver with E0/F0 prefix decoding into a show-ahead key event FIFO
module ps2_keycode_fifo import ps2_pkg::*; #(
  parameter int DEPTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                       clk_100Mhz,
  input  logic                       rst,
  input  logic                       PS2Clk,
  input  logic                       PS2Data,
  input  logic                       rd_en,
  output logic                       valid,
  output logic [7:0]                 code,
  output logic                       is_break,
  output logic                       is_ext,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  output logic                       parity_err,
  output logic                       frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [7:0] rx_byte;
  logic byte_ok, ext_pend, brk_pend, push, do_pop, do_push;
  logic [ENTRY_W-1:0] push_entry, head;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  ps2_frame_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_100Mhz(clk_100Mhz),
    .rst(rst),
    .PS2Clk(PS2Clk),
    .PS2Data(PS2Data),
    .rx_byte(rx_byte),
    .byte_ok(byte_ok),
    .parity_err(parity_err),
    .frame_err(frame_err)
  );
  assign valid    = count != '0;
  assign full     = count == CW'(DEPTH);
  assign do_pop   = rd_en & valid;
  assign do_push  = push & (~full | do_pop);
  assign head     = mem[rd_ptr];
  assign code     = valid ? head[CODE_LSB +: 8] : 8'h00;
  assign is_break = valid & head[BRK_BIT];
  assign is_ext   = valid & head[EXT_BIT];
  // fold E0/F0 prefixes into flags and emit one event per real scan code
  always_ff @(posedge clk_100Mhz or posedge rst)
    if (rst) begin
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      push       <= 1'b0;
      push_entry <= '0;
    end else begin
      push <= 1'b0;
      if (parity_err || frame_err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_ok) begin
        if (rx_byte == PS2_EXT) ext_pend <= 1'b1;
        else if (rx_byte == PS2_BRK) brk_pend <= 1'b1;
        else begin
          push       <= 1'b1;
          push_entry <= {ext_pend, brk_pend, rx_byte};
          ext_pend   <= 1'b0;
          brk_pend   <= 1'b0;
        end
      end
    end
  // FIFO pointers, occupancy and sticky overflow on a dropped event
  always_ff @(posedge clk_100Mhz or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr   <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      count    <= count + CW'(do_push) - CW'(do_pop);
      overflow <= overflow | (push & full & ~do_pop);
    end
  // entry storage; the head is read combinationally for show-ahead
  always_ff @(posedge clk_100Mhz)
    if (do_push) mem[wr_ptr] <= push_entry;
endmodule
